// File: rtl/cfg_serializer_pkg.sv
// Shared types and constants for the serial configuration master.
package cfg_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ENABLE = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOW    = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam int unsigned CFG_DEFAULT_WIDTH = 33;
    localparam logic [CFG_DEFAULT_WIDTH-1:0] CFG_DEFAULT_WORD = 33'h0_3C00_0000;

endpackage

// File: rtl/cfg_serializer_shreg.sv
// Parallel-load shift register with selectable bit order; serial data enters
// at the end opposite to the serial output and vacated positions take sin_i.
module cfg_serializer_shreg #(
    parameter int unsigned WIDTH     = 33,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic             sout_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] shifted_c;

    generate
        if (WIDTH == 1) begin : g_w1
            assign shifted_c = sin_i;
        end else if (LSB_FIRST) begin : g_lsb
            assign shifted_c = {sin_i, sh_q[WIDTH-1:1]};
        end else begin : g_msb
            assign shifted_c = {sh_q[WIDTH-2:0], sin_i};
        end
    endgenerate

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            sh_d = shifted_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_o    = sh_q;
    assign sout_o = LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];

endmodule

// File: rtl/cfg_serializer.sv
// Serial configuration master: shifts a CFG_WIDTH-bit word out as ser_en/ser_clk/ser_data.
// Define CFG_SERIALIZER_READBACK_EN to add ser_din capture and the rb_data port.
module cfg_serializer
    import cfg_serializer_pkg::*;
#(
    parameter int unsigned CFG_WIDTH = CFG_DEFAULT_WIDTH,
    parameter int unsigned CLK_DIV   = 1,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CFG_WIDTH-1:0] cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic                 ser_en,
    output logic                 ser_clk,
    output logic                 ser_data
`ifdef CFG_SERIALIZER_READBACK_EN
    ,
    input  logic                 ser_din,
    output logic [CFG_WIDTH-1:0] rb_data
`endif
);

    localparam int unsigned BIT_W = $clog2(CFG_WIDTH + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CFG_WIDTH - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ser_en_q, ser_en_d;
    logic               ser_clk_q, ser_clk_d;
    logic               load_c;
    logic               shift_c;
    logic               div_last_c;
    logic               tx_sout;
    logic [CFG_WIDTH-1:0] tx_par_unused;

    assign div_last_c = (div_q == LAST_DIV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            div_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ser_en_q  <= 1'b0;
            ser_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ser_en_q  <= ser_en_d;
            ser_clk_q <= ser_clk_d;
        end
    end

    // Outputs are decoded from the next state so each registered output matches its state.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        div_d   = div_q;
        load_c  = 1'b0;
        shift_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_ENABLE;
            end
            ST_ENABLE: begin
                div_d   = '0;
                state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (div_last_c) begin
                    div_d   = '0;
                    state_d = ST_LOW;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_LOW: begin
                if (div_last_c) begin
                    div_d   = '0;
                    shift_c = 1'b1;
                    bit_d   = bit_q + BIT_W'(1);
                    state_d = (bit_q == LAST_BIT) ? ST_DONE : ST_HIGH;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        ser_clk_d = (state_d == ST_HIGH);
        ser_en_d  = ser_en_q;
        case (state_d)
            ST_IDLE: ser_en_d = ser_en_q;
            ST_LOAD: ser_en_d = 1'b0;
            default: ser_en_d = 1'b1;
        endcase
    end

    cfg_serializer_shreg #(
        .WIDTH     (CFG_WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_tx_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_c),
        .data_i  (cfg_data),
        .shift_i (shift_c),
        .sin_i   (1'b0),
        .sout_o  (tx_sout),
        .q_o     (tx_par_unused)
    );

`ifdef CFG_SERIALIZER_READBACK_EN
    logic                 cap_shift_c;
    logic                 cap_sout_unused;
    logic [CFG_WIDTH-1:0] cap_q;
    logic [CFG_WIDTH-1:0] rb_q;

    // Sample ser_din at the end of each high phase, while the core drives it stably.
    assign cap_shift_c = (state_q == ST_HIGH) && div_last_c;

    cfg_serializer_shreg #(
        .WIDTH     (CFG_WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_rb_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_c),
        .data_i  ({CFG_WIDTH{1'b0}}),
        .shift_i (cap_shift_c),
        .sin_i   (ser_din),
        .sout_o  (cap_sout_unused),
        .q_o     (cap_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_q <= '0;
        end else if (state_d == ST_DONE) begin
            rb_q <= cap_q;
        end
    end

    assign rb_data = rb_q;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign ser_en   = ser_en_q;
    assign ser_clk  = ser_clk_q;
    assign ser_data = tx_sout;

endmodule

// File: tb/tb_cfg_serializer.sv
// Scoreboard bench for cfg_serializer: default instance plus an 8-bit MSB-first, CLK_DIV=3 instance.
module tb_cfg_serializer;

    localparam int unsigned A_W = 33;
    localparam int unsigned A_D = 1;
    localparam int unsigned B_W = 8;
    localparam int unsigned B_D = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           a_start, a_busy, a_done, a_ser_en, a_ser_clk, a_ser_data;
    logic [A_W-1:0] a_cfg;
    logic           b_start, b_busy, b_done, b_ser_en, b_ser_clk, b_ser_data;
    logic [B_W-1:0] b_cfg;
`ifdef CFG_SERIALIZER_READBACK_EN
    logic [A_W-1:0] a_rb;
    logic [B_W-1:0] b_rb;
`endif

    cfg_serializer u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (a_start),
        .cfg_data (a_cfg),
        .busy     (a_busy),
        .done     (a_done),
        .ser_en   (a_ser_en),
        .ser_clk  (a_ser_clk),
        .ser_data (a_ser_data)
`ifdef CFG_SERIALIZER_READBACK_EN
        ,
        .ser_din  (a_ser_data),
        .rb_data  (a_rb)
`endif
    );

    cfg_serializer #(
        .CFG_WIDTH (B_W),
        .CLK_DIV   (B_D),
        .LSB_FIRST (1'b0)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (b_start),
        .cfg_data (b_cfg),
        .busy     (b_busy),
        .done     (b_done),
        .ser_en   (b_ser_en),
        .ser_clk  (b_ser_clk),
        .ser_data (b_ser_data)
`ifdef CFG_SERIALIZER_READBACK_EN
        ,
        .ser_din  (b_ser_data),
        .rb_data  (b_rb)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic a_exp_q[$];
    logic b_exp_q[$];
    int unsigned a_rises = 0, b_rises = 0, a_done_cnt = 0;
    int unsigned a_acc = 0, b_acc = 0;
    logic a_clk_prev = 1'b0, a_data_prev = 1'b0;
    logic b_clk_prev = 1'b0, b_data_prev = 1'b0, b_lo_valid = 1'b0;
    int unsigned b_hi = 0, b_lo = 0;

    // Instance A monitor: each ser_clk rise pops the next expected bit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ser_clk && !a_clk_prev) begin
                a_rises++;
                check("a_q_nonempty", 64'(a_exp_q.size() != 0), 1);
                if (a_exp_q.size() != 0) check("a_bit", a_ser_data, a_exp_q.pop_front());
                check("a_en_at_rise", a_ser_en, 1);
            end
            if (a_done) a_done_cnt++;
        end
        a_clk_prev  = a_ser_clk;
        a_data_prev = a_ser_data;
    end

    // Instance B monitor: bit values plus high/low phase lengths.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b_ser_clk && !b_clk_prev) begin
                if (b_lo_valid) check("b_lo_len", b_lo, B_D);
                b_hi = 1;
                b_rises++;
                check("b_q_nonempty", 64'(b_exp_q.size() != 0), 1);
                if (b_exp_q.size() != 0) check("b_bit", b_ser_data, b_exp_q.pop_front());
            end else if (b_ser_clk) begin
                b_hi++;
                check("b_data_stable_hi", b_ser_data, b_data_prev);
            end else if (b_clk_prev) begin
                check("b_hi_len", b_hi, B_D);
                b_lo = 1;
                b_lo_valid = 1'b1;
            end else begin
                b_lo++;
            end
            if (b_done) b_lo_valid = 1'b0;
        end
        b_clk_prev  = b_ser_clk;
        b_data_prev = b_ser_data;
    end

    task automatic a_send(input logic [A_W-1:0] word);
        @(negedge clk);
        a_cfg   = word;
        a_start = 1'b1;
        for (int i = 0; i < int'(A_W); i++) a_exp_q.push_back(word[i]);
        a_acc = cyc;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic b_send(input logic [B_W-1:0] word);
        @(negedge clk);
        b_cfg   = word;
        b_start = 1'b1;
        for (int i = int'(B_W) - 1; i >= 0; i--) b_exp_q.push_back(word[i]);
        b_acc = cyc;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic a_wait_done(output int unsigned lat);
        lat = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                lat = cyc - a_acc;
                break;
            end
        end
    endtask

    task automatic b_wait_done(output int unsigned lat);
        lat = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (b_done === 1'b1) begin
                lat = cyc - b_acc;
                break;
            end
        end
    endtask

    initial begin
        int unsigned lat, r0, d0;
        logic [A_W-1:0] w1, w2;

        a_start = 1'b0; a_cfg = '0;
        b_start = 1'b0; b_cfg = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",     a_busy,     0);
        check("rst_done",     a_done,     0);
        check("rst_ser_en",   a_ser_en,   0);
        check("rst_ser_clk",  a_ser_clk,  0);
        check("rst_ser_data", a_ser_data, 0);
        check("rst_b_busy",   b_busy,     0);
`ifdef CFG_SERIALIZER_READBACK_EN
        check("rst_rb_data",  a_rb,       0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Default word: 33 rises, ones only at rises 27..30.
        r0 = a_rises;
        a_send(33'h0_3C00_0000);
        check("a1_busy", a_busy, 1);
        check("a1_load_en", a_ser_en, 0);
        a_wait_done(lat);
        check("a1_latency", lat, 3 + 2 * A_D * A_W);
        check("a1_rises", a_rises - r0, A_W);
        check("a1_q_empty", a_exp_q.size(), 0);
        @(negedge clk);
        check("a1_done_pulse", a_done, 0);
        check("a1_busy_fall", a_busy, 0);
        check("a1_en_hold", a_ser_en, 1);

        // MSB-first 8-bit word with divided serial clock.
        r0 = b_rises;
        b_send(8'hA5);
        b_wait_done(lat);
        check("b_latency", lat, 3 + 2 * B_D * B_W);
        check("b_rises", b_rises - r0, B_W);
        check("b_q_empty", b_exp_q.size(), 0);
        @(negedge clk);
        check("b_en_hold", b_ser_en, 1);

        // Restart while busy is ignored; held start chains a second transfer.
        w1 = A_W'({$urandom, $urandom});
        w2 = ~w1;
        r0 = a_rises;
        @(negedge clk);
        a_cfg   = w1;
        a_start = 1'b1;
        for (int i = 0; i < int'(A_W); i++) a_exp_q.push_back(w1[i]);
        a_acc = cyc;
        @(negedge clk);
        a_start = 1'b0;
        while ((cyc - a_acc) < 10) @(negedge clk);
        a_cfg   = w2;
        a_start = 1'b1;
        for (int i = 0; i < int'(A_W); i++) a_exp_q.push_back(w2[i]);
        check("a3_busy_mid", a_busy, 1);
        a_wait_done(lat);
        check("a3_latency1", lat, 3 + 2 * A_D * A_W);
        @(negedge clk);
        check("a3_idle_busy", a_busy, 0);
        check("a3_idle_en", a_ser_en, 1);
        a_acc = cyc;
        @(negedge clk);
        check("a3_load_busy", a_busy, 1);
        check("a3_load_en", a_ser_en, 0);
        a_start = 1'b0;
        a_wait_done(lat);
        check("a3_latency2", lat, 3 + 2 * A_D * A_W);
        check("a3_rises", a_rises - r0, 2 * A_W);
        check("a3_q_empty", a_exp_q.size(), 0);

        // Asynchronous reset mid-transfer abandons it without done.
        a_send(33'h1_5555_AAAA);
        for (int i = 0; i < 100 && (cyc - a_acc) < 20; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_busy",     a_busy,     0);
        check("ar_done",     a_done,     0);
        check("ar_ser_en",   a_ser_en,   0);
        check("ar_ser_clk",  a_ser_clk,  0);
        check("ar_ser_data", a_ser_data, 0);
        a_exp_q.delete();
        d0 = a_done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("ar_no_done", a_done_cnt - d0, 0);
        check("ar_idle_en", a_ser_en, 0);
        r0 = a_rises;
        a_send(33'h0_F0F0_0F0F);
        a_wait_done(lat);
        check("ar_latency", lat, 3 + 2 * A_D * A_W);
        check("ar_rises", a_rises - r0, A_W);
        check("ar_q_empty", a_exp_q.size(), 0);

`ifdef CFG_SERIALIZER_READBACK_EN
        a_send(33'h1_2345_6789);
        a_wait_done(lat);
        check("rb_a_data", a_rb, 33'h1_2345_6789);
        b_send(8'h3C);
        b_wait_done(lat);
        check("rb_b_data", b_rb, 8'h3C);
        repeat (5) @(negedge clk);
        check("rb_a_hold", a_rb, 33'h1_2345_6789);
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
